alu_control_sequencer: RTL and testbench

- Hardwired control unit that drives the DataPath strobes (PCout, MARin, MDRin, IRin, Yin, ZLowIn, …) which the directed benches currently hand-sequence.
- Runs fetch (T0–T2) and register-register ALU execute (T3–T5, T6 for MUL/DIV) from the IR contents.
- Connects to the DataPath through a thin wiring wrapper; one-hot register vectors fan out to R0in..R15in and R0out..R15out.

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/reg_select_decoder.sv | 13 +
 rtl/alu_control_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired fetch/execute control unit:
// opcodes, controller states and IR field positions.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6
    } state_e;

    function automatic logic is_one_word(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_one_word = 1'b1;
            default:                         is_one_word = 1'b0;
        endcase
    endfunction

    function automatic logic is_two_word(input logic [4:0] op);
        is_two_word = (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index to 16-bit one-hot select, all-zero when disabled.
module reg_select_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and register-register ALU execute
// (T3-T5, T6 for two-word results) driving the DataPath strobes.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MDRout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             ZLowIn,
    output logic             ZHighIn,
    output logic             HIin,
    output logic             LOin,
    output logic [15:0]      reg_in,
    output logic [15:0]      reg_out,
    output logic [4:0]       opcode,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_e             state_q, state_d;
    logic [3:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       one_word, two_word;
    logic       out_en, in_en;
    logic [3:0] out_idx;
    logic       ir_unused;

    assign op        = ir[OP_MSB:OP_LSB];
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign rc        = ir[RC_MSB:RC_LSB];
    assign one_word  = is_one_word(op);
    assign two_word  = is_two_word(op);
    assign ir_unused = ^ir[RC_LSB-1:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        count_d    = count_q;
        PCout      = 1'b0;
        MDRout     = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Read       = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        ZLowIn     = 1'b0;
        ZHighIn    = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        opcode     = '0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        out_en     = 1'b0;
        out_idx    = rc;
        in_en      = 1'b0;

        unique case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                PCin    = 1'b1;
                wait_d  = 4'(MEM_WAIT);
                state_d = S_T1;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (wait_q == '0) state_d = S_T2;
                else              wait_d  = wait_q - 4'd1;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                // Unsupported opcodes end the instruction here without touching the bus.
                if (one_word || two_word) begin
                    out_en  = 1'b1;
                    out_idx = rc;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                out_en  = 1'b1;
                out_idx = rb;
                ZLowIn  = 1'b1;
                ZHighIn = two_word;
                opcode  = op;
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (two_word) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    in_en      = 1'b1;
                    instr_done = 1'b1;
                    count_d    = count_q + CNT_W'(1);
                    state_d    = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
                count_d    = count_q + CNT_W'(1);
                state_d    = run ? S_T0 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign instr_count = count_q;

    reg_select_decoder u_out_dec (
        .idx    (out_idx),
        .en     (out_en),
        .onehot (reg_out)
    );

    reg_select_decoder u_in_dec (
        .idx    (ra),
        .en     (in_en),
        .onehot (reg_in)
    );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: three instances cover MEM_WAIT 0/3/5
// and a narrow counter for wraparound; inactive instances are held in clear.
module tb_alu_control_sequencer;

    localparam int PCOUT = 0, MDROUT = 1, ZLOWOUT = 2, ZHIGHOUT = 3, PCIN = 4, INCPC = 5;
    localparam int MARIN = 6, MDRIN = 7, READ = 8, IRIN = 9, YIN = 10, ZLOWIN = 11;
    localparam int ZHIGHIN = 12, HIIN = 13, LOIN = 14, IDONE = 15, ILL = 16, BUSY = 17;

    localparam logic [17:0] M_IDLE = '0;
    localparam logic [17:0] M_T0   = 18'((1 << PCOUT) | (1 << PCIN) | (1 << INCPC) | (1 << MARIN) | (1 << BUSY));
    localparam logic [17:0] M_T1   = 18'((1 << MDRIN) | (1 << READ) | (1 << BUSY));
    localparam logic [17:0] M_T2   = 18'((1 << MDROUT) | (1 << IRIN) | (1 << BUSY));
    localparam logic [17:0] M_T3   = 18'((1 << YIN) | (1 << BUSY));
    localparam logic [17:0] M_T3I  = 18'((1 << ILL) | (1 << BUSY));
    localparam logic [17:0] M_T4   = 18'((1 << ZLOWIN) | (1 << BUSY));
    localparam logic [17:0] M_T4M  = 18'((1 << ZLOWIN) | (1 << ZHIGHIN) | (1 << BUSY));
    localparam logic [17:0] M_T5   = 18'((1 << ZLOWOUT) | (1 << IDONE) | (1 << BUSY));
    localparam logic [17:0] M_T5M  = 18'((1 << ZLOWOUT) | (1 << LOIN) | (1 << BUSY));
    localparam logic [17:0] M_T6   = 18'((1 << ZHIGHOUT) | (1 << HIIN) | (1 << IDONE) | (1 << BUSY));

    localparam logic [31:0] IR_ADD = 32'h1A1B_8000;
    localparam logic [31:0] IR_MUL = 32'h7A1B_8000;
    localparam logic [31:0] IR_ILL = 32'hF800_0000;

    logic        clock = 1'b0;
    logic [2:0]  clr;
    logic        run;
    logic [31:0] ir;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned MW = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        localparam int unsigned CW = (g == 1) ? 2 : 16;
        logic [17:0]   s;
        logic [15:0]   rin, rout;
        logic [4:0]    opc;
        logic [CW-1:0] cnt;
        logic [15:0]   cnt16;
        assign cnt16 = 16'(cnt);

        alu_control_sequencer #(.MEM_WAIT(MW), .CNT_W(CW)) u_dut (
            .clock       (clock),
            .clear       (clr[g]),
            .run         (run),
            .ir          (ir),
            .PCout       (s[PCOUT]),
            .MDRout      (s[MDROUT]),
            .Zlowout     (s[ZLOWOUT]),
            .Zhighout    (s[ZHIGHOUT]),
            .PCin        (s[PCIN]),
            .IncPC       (s[INCPC]),
            .MARin       (s[MARIN]),
            .MDRin       (s[MDRIN]),
            .Read        (s[READ]),
            .IRin        (s[IRIN]),
            .Yin         (s[YIN]),
            .ZLowIn      (s[ZLOWIN]),
            .ZHighIn     (s[ZHIGHIN]),
            .HIin        (s[HIIN]),
            .LOin        (s[LOIN]),
            .reg_in      (rin),
            .reg_out     (rout),
            .opcode      (opc),
            .busy        (s[BUSY]),
            .instr_done  (s[IDONE]),
            .illegal_op  (s[ILL]),
            .instr_count (cnt)
        );
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 3'b111;
        run = 1'b0;
        ir  = '0;
        step();
        step();

        chk("rst_sig",  32'(g_dut[0].s), 32'(M_IDLE));
        chk("rst_cnt",  32'(g_dut[0].cnt16), 32'h0);
        chk("rst_rout", 32'(g_dut[0].rout), 32'h0);

        clr[0] = 1'b0;
        run    = 1'b1;
        ir     = IR_ADD;
        step(); chk("add_t0", 32'(g_dut[0].s), 32'(M_T0));
        step(); chk("add_t1", 32'(g_dut[0].s), 32'(M_T1));
        step(); chk("add_t2", 32'(g_dut[0].s), 32'(M_T2));
        step(); chk("add_t3", 32'(g_dut[0].s), 32'(M_T3));
                chk("add_t3_rout", 32'(g_dut[0].rout), 32'h0080);
                chk("add_t3_opc", 32'(g_dut[0].opc), 32'h0);
        step(); chk("add_t4", 32'(g_dut[0].s), 32'(M_T4));
                chk("add_t4_rout", 32'(g_dut[0].rout), 32'h0008);
                chk("add_t4_opc", 32'(g_dut[0].opc), 32'h03);
        step(); chk("add_t5", 32'(g_dut[0].s), 32'(M_T5));
                chk("add_t5_rin", 32'(g_dut[0].rin), 32'h0010);
                chk("add_t5_rout", 32'(g_dut[0].rout), 32'h0);
                chk("add_t5_cnt", 32'(g_dut[0].cnt16), 32'h0);
        step(); chk("add_next_t0", 32'(g_dut[0].s), 32'(M_T0));
                chk("add_cnt", 32'(g_dut[0].cnt16), 32'h1);

        ir = IR_MUL;
        repeat (3) step();
        chk("mul_t3", 32'(g_dut[0].s), 32'(M_T3));
        step(); chk("mul_t4", 32'(g_dut[0].s), 32'(M_T4M));
                chk("mul_t4_opc", 32'(g_dut[0].opc), 32'h0F);
        step(); chk("mul_t5", 32'(g_dut[0].s), 32'(M_T5M));
                chk("mul_t5_rin", 32'(g_dut[0].rin), 32'h0);
        step(); chk("mul_t6", 32'(g_dut[0].s), 32'(M_T6));
                chk("mul_t6_rin", 32'(g_dut[0].rin), 32'h0);
        step(); chk("mul_next_t0", 32'(g_dut[0].s), 32'(M_T0));
                chk("mul_cnt", 32'(g_dut[0].cnt16), 32'h2);

        ir = IR_ILL;
        repeat (3) step();
        chk("ill_t3", 32'(g_dut[0].s), 32'(M_T3I));
        step(); chk("ill_next_t0", 32'(g_dut[0].s), 32'(M_T0));
                chk("ill_cnt", 32'(g_dut[0].cnt16), 32'h2);

        ir = IR_ADD;
        repeat (4) step();
        chk("drop_t4", 32'(g_dut[0].s), 32'(M_T4));
        run = 1'b0;
        step(); chk("drop_t5", 32'(g_dut[0].s), 32'(M_T5));
        step(); chk("drop_idle", 32'(g_dut[0].s), 32'(M_IDLE));
                chk("drop_cnt", 32'(g_dut[0].cnt16), 32'h3);
        step(); chk("drop_idle2", 32'(g_dut[0].s), 32'(M_IDLE));
        run = 1'b1;
        step(); chk("rerun_t0", 32'(g_dut[0].s), 32'(M_T0));

        clr[0] = 1'b1;
        clr[1] = 1'b0;
        step(); chk("mw3_t0", 32'(g_dut[1].s), 32'(M_T0));
        for (int i = 0; i < 4; i++) begin
            step(); chk("mw3_t1", 32'(g_dut[1].s), 32'(M_T1));
        end
        step(); chk("mw3_t2", 32'(g_dut[1].s), 32'(M_T2));
        repeat (4) step();
        chk("mw3_t0b", 32'(g_dut[1].s), 32'(M_T0));
        chk("mw3_cnt1", 32'(g_dut[1].cnt16), 32'h1);
        for (int k = 0; k < 3; k++) begin
            repeat (9) step();
            chk("wrap_t0", 32'(g_dut[1].s), 32'(M_T0));
            chk("wrap_cnt", 32'(g_dut[1].cnt16), 32'((k + 2) % 4));
        end

        clr[1] = 1'b1;
        clr[2] = 1'b0;
        step(); chk("mw5_t0", 32'(g_dut[2].s), 32'(M_T0));
        repeat (6) step();
        chk("mw5_t1_last", 32'(g_dut[2].s), 32'(M_T1));
        step(); chk("mw5_t2", 32'(g_dut[2].s), 32'(M_T2));
        repeat (4) step();
        chk("mw5_cnt", 32'(g_dut[2].cnt16), 32'h1);
        step();
        step(); chk("clr_pre_t1", 32'(g_dut[2].s), 32'(M_T1));
        clr[2] = 1'b1;
        step(); chk("clr_sig", 32'(g_dut[2].s), 32'(M_IDLE));
                chk("clr_regs", 32'({g_dut[2].rin, g_dut[2].rout}), 32'h0);
                chk("clr_opc", 32'(g_dut[2].opc), 32'h0);
                chk("clr_cnt", 32'(g_dut[2].cnt16), 32'h0);
        clr[2] = 1'b0;
        run    = 1'b0;
        step(); chk("clr_idle", 32'(g_dut[2].s), 32'(M_IDLE));
        run = 1'b1;
        step(); chk("clr_rerun_t0", 32'(g_dut[2].s), 32'(M_T0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
